// File: rtl/restoration_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : restoration_pkg
//  Description : Shared definitions for the pulse propagation meter: FSM
//                state encoding, default widths and the effective-timeout
//                helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package restoration_pkg;

    // Default geometry of the meter
    localparam int DEF_NUM_CH   = 4;
    localparam int DEF_CNT_W    = 16;
    localparam int DEF_AVG_LOG2 = 2;

    // Shot FSM encoding
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BLANK   = 2'd1;
    localparam logic [1:0] ST_MEASURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    // A programmed timeout of 0 selects the largest counter value, so a shot
    // can never wait on a counter that would have to wrap. Widths up to 32.
    function automatic logic [31:0] eff_timeout(input logic [31:0] t, input int w);
        logic [63:0] max_v;
        max_v = (64'd1 << w) - 64'd1;
        if (t == 32'd0) begin
            return max_v[31:0];
        end
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pulse_edge_sync.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_edge_sync
//  Description : Two-flop synchroniser followed by a registered rising-edge
//                detector. An input first sampled high at edge E0 yields a
//                one-cycle edge_o pulse registered at E2.
//  Revision    : 1.0 - initial release
//  Ports       : clk_i      system clock
//                reset_n_i  synchronous active-low reset
//                async_i    asynchronous level input
//                edge_o     one-cycle rising-edge pulse (registered)
// ============================================================================
module pulse_edge_sync (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic async_i,
    output logic edge_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic edge_q;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            edge_q  <= sync2_q & ~prev_q;
        end
    end

    assign edge_o = edge_q;

endmodule
`default_nettype wire

// File: rtl/pulse_propagation_meter.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_propagation_meter
//  Description : Multi-channel pulse time-of-flight meter. A trigger edge
//                starts a free-running counter; the first echo per channel
//                after the blanking window is timestamped, channels missing
//                the timeout are flagged, and fully captured shots are
//                averaged over 2^AVG_LOG2 triggers.
//  Revision    : 1.0 - initial release
//  Ports       : clk_i               system clock
//                reset_n_i           synchronous active-low reset
//                trigger_req_i       async trigger level (rising edge = shot)
//                restored_pulse_i    async echo per channel
//                pulser_ic_error_i   synchronous fault, aborts the shot
//                reset_all_errors_i  clears sticky timeout flags
//                blank_cycles_i      echoes ignored while counter < this
//                timeout_cycles_i    shot timeout (0 = counter maximum)
//                tof_o / tof_valid_o last completed shot timestamps/flags
//                meas_done_o         one-cycle pulse per completed shot
//                tof_avg_o           averaged timestamps
//                avg_valid_o         one-cycle pulse, tof_avg_o updated
//                timeout_err_o       sticky per-channel missed-echo flags
//                aborted_o           one-cycle pulse, shot killed by fault
// ============================================================================
module pulse_propagation_meter
    import restoration_pkg::*;
#(
    parameter int NUM_CH   = DEF_NUM_CH,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int AVG_LOG2 = DEF_AVG_LOG2
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      trigger_req_i,
    input  logic [NUM_CH-1:0]         restored_pulse_i,
    input  logic                      pulser_ic_error_i,
    input  logic                      reset_all_errors_i,
    input  logic [CNT_W-1:0]          blank_cycles_i,
    input  logic [CNT_W-1:0]          timeout_cycles_i,
    output logic [NUM_CH*CNT_W-1:0]   tof_o,
    output logic [NUM_CH-1:0]         tof_valid_o,
    output logic                      meas_done_o,
    output logic [NUM_CH*CNT_W-1:0]   tof_avg_o,
    output logic                      avg_valid_o,
    output logic [NUM_CH-1:0]         timeout_err_o,
    output logic                      aborted_o
);

    localparam int ACC_W = CNT_W + AVG_LOG2;
    localparam int SC_W  = AVG_LOG2 + 1;
    localparam logic [SC_W-1:0] C_SHOT_LAST = SC_W'((1 << AVG_LOG2) - 1);

    // ------------------------------------------------------------------
    // Input synchronisers: identical latency on trigger and echo paths so
    // timestamps are free of synchroniser offset.
    // ------------------------------------------------------------------
    logic              w_trig_edge;
    logic [NUM_CH-1:0] w_echo_edge;

    pulse_edge_sync u_trig_sync (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .async_i   (trigger_req_i),
        .edge_o    (w_trig_edge)
    );

    for (genvar c = 0; c < NUM_CH; c++) begin : g_echo_sync
        pulse_edge_sync u_echo_sync (
            .clk_i     (clk_i),
            .reset_n_i (reset_n_i),
            .async_i   (restored_pulse_i[c]),
            .edge_o    (w_echo_edge[c])
        );
    end

    // ------------------------------------------------------------------
    // Shot control
    // ------------------------------------------------------------------
    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_CH-1:0] capt_q;
    logic [SC_W-1:0]   shot_q;
    logic [NUM_CH-1:0] tof_valid_q;
    logic [NUM_CH-1:0] timeout_err_q, timeout_err_d;
    logic              meas_done_q;
    logic              avg_valid_q;
    logic              aborted_q;

    logic [CNT_W-1:0]  w_eff_to;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_trig;
    logic              w_active;
    logic              w_start;
    logic              w_abort;
    logic [1:0]        w_start_st;
    logic              w_blank_over;
    logic              w_at_to;
    logic [NUM_CH-1:0] w_hit;
    logic [NUM_CH-1:0] w_capt_all;
    logic              w_finish;
    logic              w_good;
    logic              w_avg_last;

    assign w_eff_to     = CNT_W'(eff_timeout(32'(timeout_cycles_i), CNT_W));
    assign w_cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    // The fault masks trigger edges; the fault itself only acts outside IDLE.
    assign w_trig       = w_trig_edge & ~pulser_ic_error_i;
    assign w_active     = (state_q == ST_BLANK) || (state_q == ST_MEASURE);
    assign w_start      = w_trig & ((state_q == ST_IDLE) | w_active);
    assign w_abort      = pulser_ic_error_i & (state_q != ST_IDLE);
    assign w_start_st   = (blank_cycles_i == '0) ? ST_MEASURE : ST_BLANK;
    assign w_blank_over = ({1'b0, cnt_q} + (CNT_W+1)'(1)) >= {1'b0, blank_cycles_i};
    assign w_at_to      = cnt_q >= w_eff_to;

    // New captures this cycle; a restart or abort in the same cycle wins.
    assign w_hit      = {NUM_CH{(state_q == ST_MEASURE) & ~w_start & ~w_abort}}
                        & w_echo_edge & ~capt_q;
    assign w_capt_all = capt_q | w_hit;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        w_finish = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_trig) begin
                    state_d = w_start_st;
                    cnt_d   = '0;
                end
            end
            ST_BLANK: begin
                cnt_d = w_cnt_inc;
                // A timeout shorter than the blanking window ends the shot here.
                if (w_at_to) begin
                    state_d  = ST_DONE;
                    w_finish = 1'b1;
                end else if (w_blank_over) begin
                    state_d = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                cnt_d = w_cnt_inc;
                if ((&w_capt_all) || w_at_to) begin
                    state_d  = ST_DONE;
                    w_finish = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (w_active && w_trig) begin
            state_d  = w_start_st;
            cnt_d    = '0;
            w_finish = 1'b0;
        end
        if (w_abort) begin
            state_d  = ST_IDLE;
            w_finish = 1'b0;
        end
    end

    assign w_good     = w_finish & (&w_capt_all);
    assign w_avg_last = (shot_q == C_SHOT_LAST);

    // Set of a timeout flag outranks a coincident clear request.
    always_comb begin
        timeout_err_d = reset_all_errors_i ? '0 : timeout_err_q;
        if (w_finish) begin
            timeout_err_d = timeout_err_d | ~w_capt_all;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            capt_q        <= '0;
            shot_q        <= '0;
            tof_valid_q   <= '0;
            timeout_err_q <= '0;
            meas_done_q   <= 1'b0;
            avg_valid_q   <= 1'b0;
            aborted_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            capt_q        <= w_start ? '0 : w_capt_all;
            timeout_err_q <= timeout_err_d;
            meas_done_q   <= w_finish;
            avg_valid_q   <= w_good & w_avg_last;
            aborted_q     <= w_abort;
            if (w_finish) begin
                tof_valid_q <= w_capt_all;
            end
            if (w_good) begin
                shot_q <= w_avg_last ? '0 : shot_q + SC_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-channel shadow capture, published timestamp and accumulator
    // ------------------------------------------------------------------
    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        logic [CNT_W-1:0] shadow_q;
        logic [CNT_W-1:0] tof_q;
        logic [CNT_W-1:0] avg_q;
        logic [ACC_W-1:0] acc_q;
        logic [CNT_W-1:0] w_tof_new;
        logic [ACC_W-1:0] w_sum;

        // A capture landing in the finishing cycle is published directly.
        assign w_tof_new = w_hit[c]  ? cnt_q    :
                           capt_q[c] ? shadow_q : '1;
        assign w_sum     = acc_q + ACC_W'(w_tof_new);

        always_ff @(posedge clk_i) begin
            if (!reset_n_i) begin
                shadow_q <= '0;
                tof_q    <= '0;
                avg_q    <= '0;
                acc_q    <= '0;
            end else begin
                if (w_hit[c]) begin
                    shadow_q <= cnt_q;
                end
                if (w_finish) begin
                    tof_q <= w_tof_new;
                end
                if (w_good) begin
                    if (w_avg_last) begin
                        acc_q <= '0;
                        avg_q <= CNT_W'(w_sum >> AVG_LOG2);
                    end else begin
                        acc_q <= w_sum;
                    end
                end
            end
        end

        assign tof_o[c*CNT_W +: CNT_W]     = tof_q;
        assign tof_avg_o[c*CNT_W +: CNT_W] = avg_q;
    end

    assign tof_valid_o   = tof_valid_q;
    assign timeout_err_o = timeout_err_q;
    assign meas_done_o   = meas_done_q;
    assign avg_valid_o   = avg_valid_q;
    assign aborted_o     = aborted_q;

endmodule
`default_nettype wire

// File: tb/tb_pulse_propagation_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pulse_propagation_meter
//  Description : Scoreboard bench for pulse_propagation_meter. Each shot's
//                expected outcome is derived from arrival times and pushed
//                to a queue; a monitor pops it on meas_done/aborted.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pulse_propagation_meter;

    localparam int NCH = 4;
    localparam int CW  = 16;
    localparam int AL  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n;
    logic              trigger_req;
    logic [NCH-1:0]    restored_pulse;
    logic              pulser_ic_error;
    logic              reset_all_errors;
    logic [CW-1:0]     blank_cycles;
    logic [CW-1:0]     timeout_cycles;
    logic [NCH*CW-1:0] tof_o;
    logic [NCH-1:0]    tof_valid_o;
    logic              meas_done_o;
    logic [NCH*CW-1:0] tof_avg_o;
    logic              avg_valid_o;
    logic [NCH-1:0]    timeout_err_o;
    logic              aborted_o;

    pulse_propagation_meter #(.NUM_CH(NCH), .CNT_W(CW), .AVG_LOG2(AL)) dut (
        .clk_i              (clk),
        .reset_n_i          (reset_n),
        .trigger_req_i      (trigger_req),
        .restored_pulse_i   (restored_pulse),
        .pulser_ic_error_i  (pulser_ic_error),
        .reset_all_errors_i (reset_all_errors),
        .blank_cycles_i     (blank_cycles),
        .timeout_cycles_i   (timeout_cycles),
        .tof_o              (tof_o),
        .tof_valid_o        (tof_valid_o),
        .meas_done_o        (meas_done_o),
        .tof_avg_o          (tof_avg_o),
        .avg_valid_o        (avg_valid_o),
        .timeout_err_o      (timeout_err_o),
        .aborted_o          (aborted_o)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nchecks = 0;
    int nerrors = 0;
    int events_seen = 0;

    typedef struct {
        bit          is_abort;
        int          cyc;
        logic [63:0] tof;
        logic [3:0]  valid;
        logic [3:0]  err;
        bit          avg_v;
        logic [63:0] avg;
    } exp_t;
    exp_t sb_q[$];

    // Reference state: what the outputs should hold after the last event
    logic [63:0] m_tof;
    logic [3:0]  m_valid;
    logic [3:0]  m_err;
    logic [63:0] m_avg;
    int          m_acc [NCH];
    int          m_cnt;

    // Echo arrival delays (cycles after the trigger is raised), 0 = none
    int sh_d0 [NCH];
    int sh_d1 [NCH];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_tof = '0; m_valid = '0; m_err = '0; m_avg = '0; m_cnt = 0;
        for (int c = 0; c < NCH; c++) m_acc[c] = 0;
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            chk("avg_valid_alone", 64'(avg_valid_o & ~meas_done_o), 64'd0);
            if (meas_done_o || aborted_o) begin
                events_seen++;
                if (sb_q.size() == 0) begin
                    nchecks++;
                    nerrors++;
                    $display("FAIL unexpected_event: meas_done=%b aborted=%b expected none (cycle %0d)",
                             meas_done_o, aborted_o, cyc);
                end else begin
                    e = sb_q.pop_front();
                    chk("event_kind_aborted", 64'(aborted_o), 64'(e.is_abort));
                    chk("event_kind_done", 64'(meas_done_o), 64'(!e.is_abort));
                    chk("event_cycle", 64'(cyc), 64'(e.cyc));
                    chk("tof", tof_o, e.tof);
                    chk("tof_valid", 64'(tof_valid_o), 64'(e.valid));
                    chk("timeout_err", 64'(timeout_err_o), 64'(e.err));
                    chk("avg_valid", 64'(avg_valid_o), 64'(e.avg_v));
                    chk("tof_avg", tof_avg_o, e.avg);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Shot driver + reference model.
    // The counter is 0 on the edge the trigger event is acted on, and an
    // echo passes the same synchroniser, so an echo raised d cycles after
    // the trigger is stamped d-1.
    // off : if > 0, a retrigger d cycles after the first trigger; echoes are
    //       relative to the retrigger and the first shot is dropped.
    // a   : if > 0, pulser fault raised a cycles after the (last) trigger.
    // rae : raise reset_all_errors in the cycle the shot completes.
    // ------------------------------------------------------------------
    task automatic run_shot(input int b, input int to, input int off, input int a, input bit rae);
        int   eff, endc, maxd, len, P, rel;
        int   t [NCH];
        bit   cap [NCH];
        bit   allc;
        exp_t e;

        blank_cycles   = CW'(b);
        timeout_cycles = CW'(to);
        eff  = (to == 0) ? 65535 : to;
        allc = 1'b1;
        endc = 0;
        maxd = 0;
        for (int c = 0; c < NCH; c++) begin
            cap[c] = 1'b0;
            t[c]   = 0;
            if (sh_d0[c] > 0 && sh_d0[c] - 1 >= b && sh_d0[c] - 1 <= eff) begin
                cap[c] = 1'b1; t[c] = sh_d0[c] - 1;
            end else if (sh_d1[c] > 0 && sh_d1[c] - 1 >= b && sh_d1[c] - 1 <= eff) begin
                cap[c] = 1'b1; t[c] = sh_d1[c] - 1;
            end
            if (!cap[c]) allc = 1'b0;
            else if (t[c] > endc) endc = t[c];
            if (sh_d0[c] > maxd) maxd = sh_d0[c];
            if (sh_d1[c] > maxd) maxd = sh_d1[c];
        end
        if (!allc) endc = eff;

        @(negedge clk);
        P = cyc;

        e.is_abort = (a > 0);
        if (a > 0) begin
            e.cyc = P + off + a + 1;
            e.tof = m_tof; e.valid = m_valid; e.err = m_err; e.avg_v = 1'b0; e.avg = m_avg;
        end else begin
            e.cyc = P + off + endc + 5;
            for (int c = 0; c < NCH; c++) begin
                m_tof[c*CW +: CW] = cap[c] ? CW'(t[c]) : {CW{1'b1}};
                m_valid[c]        = cap[c];
            end
            m_err = (rae ? 4'b0 : m_err) | ~m_valid;
            e.avg_v = 1'b0;
            if (allc) begin
                for (int c = 0; c < NCH; c++) m_acc[c] += t[c];
                m_cnt++;
                if (m_cnt == (1 << AL)) begin
                    for (int c = 0; c < NCH; c++) begin
                        m_avg[c*CW +: CW] = CW'(m_acc[c] / (1 << AL));
                        m_acc[c] = 0;
                    end
                    m_cnt   = 0;
                    e.avg_v = 1'b1;
                end
            end
            e.tof = m_tof; e.valid = m_valid; e.err = m_err; e.avg = m_avg;
        end
        sb_q.push_back(e);

        len = off + ((endc > maxd) ? endc : maxd) + 8;
        for (int j = 0; j <= len; j++) begin
            rel = j - off;
            trigger_req      = (j == 0 || j == 1) || (off > 0 && (j == off || j == off + 1));
            for (int c = 0; c < NCH; c++) begin
                restored_pulse[c] = (sh_d0[c] > 0 && (rel == sh_d0[c] || rel == sh_d0[c] + 1)) ||
                                    (sh_d1[c] > 0 && (rel == sh_d1[c] || rel == sh_d1[c] + 1));
            end
            pulser_ic_error  = (a > 0) && (rel == a);
            reset_all_errors = rae && (rel == endc + 4);
            @(negedge clk);
        end
        trigger_req = 1'b0; restored_pulse = '0; pulser_ic_error = 1'b0; reset_all_errors = 1'b0;
    endtask

    task automatic set_delays(input int a0, input int a1, input int a2, input int a3);
        sh_d0[0] = a0; sh_d0[1] = a1; sh_d0[2] = a2; sh_d0[3] = a3;
        for (int c = 0; c < NCH; c++) sh_d1[c] = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_tof"}, tof_o, 64'd0);
        chk({tag, "_tof_valid"}, 64'(tof_valid_o), 64'd0);
        chk({tag, "_meas_done"}, 64'(meas_done_o), 64'd0);
        chk({tag, "_tof_avg"}, tof_avg_o, 64'd0);
        chk({tag, "_avg_valid"}, 64'(avg_valid_o), 64'd0);
        chk({tag, "_timeout_err"}, 64'(timeout_err_o), 64'd0);
        chk({tag, "_aborted"}, 64'(aborted_o), 64'd0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d expected events pending", sb_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int ev0, b, to, w;
        reset_n = 1'b0; trigger_req = 1'b0; restored_pulse = '0;
        pulser_ic_error = 1'b0; reset_all_errors = 1'b0;
        blank_cycles = '0; timeout_cycles = '0;
        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_all_zero("reset");

        // All four channels echo
        set_delays(50, 60, 70, 80);
        run_shot(10, 1000, 0, 0, 1'b0);

        // Channel 2 silent -> timeout at 200
        set_delays(50, 60, 0, 80);
        run_shot(10, 200, 0, 0, 1'b0);

        // Clear sticky errors
        reset_all_errors = 1'b1;
        @(negedge clk);
        reset_all_errors = 1'b0;
        m_err = 4'b0;
        chk("err_cleared", 64'(timeout_err_o), 64'(m_err));

        // Set an error, then a second timeout shot with a coincident clear
        set_delays(50, 60, 70, 0);
        run_shot(10, 200, 0, 0, 1'b0);
        set_delays(50, 60, 0, 80);
        run_shot(10, 200, 0, 0, 1'b1);

        // Echo inside the blanking window is ignored, repeat is captured
        set_delays(6, 40, 45, 50);
        sh_d1[0] = 31;
        run_shot(10, 1000, 0, 0, 1'b0);

        // Fault mid-MEASURE at counter 40
        set_delays(200, 210, 220, 230);
        run_shot(10, 1000, 0, 44, 1'b0);

        // Trigger event coincident with the fault is ignored
        ev0 = events_seen;
        @(negedge clk);
        for (int j = 0; j < 40; j++) begin
            trigger_req     = (j == 0 || j == 1);
            pulser_ic_error = (j == 3);
            @(negedge clk);
        end
        trigger_req = 1'b0; pulser_ic_error = 1'b0;
        chk("trig_with_err_no_event", 64'(events_seen), 64'(ev0));

        // Retrigger at counter 30: only the second shot completes
        set_delays(60, 65, 70, 75);
        run_shot(10, 1000, 31, 0, 1'b0);

        // Reset in the middle of a shot
        blank_cycles = CW'(10); timeout_cycles = CW'(1000);
        @(negedge clk);
        for (int j = 0; j < 20; j++) begin
            trigger_req = (j == 0 || j == 1);
            @(negedge clk);
        end
        trigger_req = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        check_all_zero("midshot_reset");
        reset_n = 1'b1;
        model_reset();
        repeat (4) @(negedge clk);

        // Averaging: ch0 = 100, 101, (timeout shot), 102, 104
        set_delays(101, 150, 160, 170); run_shot(10, 1000, 0, 0, 1'b0);
        set_delays(102, 150, 160, 170); run_shot(10, 1000, 0, 0, 1'b0);
        set_delays(103, 150, 160, 0);   run_shot(10, 200, 0, 0, 1'b0);
        set_delays(103, 150, 160, 170); run_shot(10, 1000, 0, 0, 1'b0);
        set_delays(105, 150, 160, 170); run_shot(10, 1000, 0, 0, 1'b0);

        // Randomised shots
        for (int s = 0; s < 20; s++) begin
            b  = int'($urandom_range(0, 30));
            to = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(80, 400));
            for (int c = 0; c < NCH; c++) begin
                sh_d1[c] = 0;
                if (to == 0) begin
                    sh_d0[c] = int'($urandom_range(b + 1, b + 300));
                end else begin
                    sh_d0[c] = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 350));
                    if (sh_d0[c] > 0 && $urandom_range(0, 3) == 0)
                        sh_d1[c] = sh_d0[c] + int'($urandom_range(5, 40));
                end
            end
            run_shot(b, to, 0, 0, 1'b0);
        end

        w = 0;
        while (sb_q.size() > 0 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (sb_q.size() > 0) begin
            nchecks++;
            nerrors++;
            $display("FAIL pending_events: got %0d outstanding expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pulse_propagation_meter.md
# pulse_propagation_meter

Multi-channel pulse time-of-flight meter for the HV carrier. It starts a free-running counter on each pulser trigger. It then timestamps the first restored echo on each of NUM_CH channels after a programmable blanking window, and flags channels that miss a programmable timeout. Qualified shots are also averaged over 2^AVG_LOG2 triggers. It sits between the pulser trigger logic and the tissue-temperature computation, and generalises the single-channel propagation counter.

## Interface
- NUM_CH, 4, number of restored-pulse channels (1..8)
- CNT_W, 16, counter and timestamp width
- AVG_LOG2, 2, log2 of shots per average (0 = no averaging, every good shot publishes)
- clk  in  1  system clock
- reset_n  in  1  reset; one clock; reset is synchronous and active-low
- trigger_req  in  1  pulser trigger request, asynchronous level; rising edge starts a shot
- restored_pulse  in  NUM_CH  restored echo per channel, asynchronous; rising edge = arrival
- pulser_ic_error  in  1  pulser fault level, synchronous; aborts the shot
- reset_all_errors  in  1  synchronous clear of sticky error flags
- blank_cycles  in  CNT_W  echoes ignored while counter < blank_cycles
- timeout_cycles  in  CNT_W  shot ends when counter == timeout_cycles; 0 means 2^CNT_W-1
- tof  out  NUM_CH*CNT_W  last-shot timestamp per channel, channel c at [c*CNT_W +: CNT_W]
- tof_valid  out  NUM_CH  per channel, 1 = echo captured in last completed shot
- meas_done  out  1  one-cycle pulse, shot completed
- tof_avg  out  NUM_CH*CNT_W  averaged timestamps
- avg_valid  out  1  one-cycle pulse, tof_avg updated
- timeout_err  out  NUM_CH  sticky, channel missed its echo
- aborted  out  1  one-cycle pulse, shot killed by pulser_ic_error

## Operation
- Reset: all outputs, counter, accumulators and shot count are 0, and the FSM is in IDLE.
- Edge detection: each async input passes a 2-flop synchroniser, then a registered rising-edge detector.
- FSM states: IDLE, BLANK, MEASURE, DONE.
- IDLE: on a trigger edge, counter := 0, per-shot capture flags cleared, go to BLANK.
- BLANK: counter increments; echo edges are ignored. Go to MEASURE when counter+1 >= blank_cycles. blank_cycles = 0 enters MEASURE directly from IDLE.
- MEASURE: counter increments. The first echo edge on channel c latches the current counter into a shadow tof[c] and sets its capture flag; later edges are ignored. Go to DONE when all capture flags are set, or when counter == effective timeout.
- DONE: lasts one cycle.
  - Shadow captures are copied to tof and tof_valid.
  - Uncaptured channels: tof[c] = all-ones, tof_valid[c] = 0, timeout_err[c] set.
  - meas_done pulses; return to IDLE.
- Averaging: a shot counts only if every channel captured.
  - A good shot adds each tof[c] into a (CNT_W+AVG_LOG2)-bit accumulator.
  - On the 2^AVG_LOG2-th good shot: tof_avg[c] = acc >> AVG_LOG2 (truncated), avg_valid pulses, accumulators and shot count clear.
  - Failed shots are discarded but do not reset an accumulation in progress.
- Retrigger: a trigger edge in BLANK or MEASURE restarts the shot (counter 0, flags cleared, BLANK). The partial shot is dropped; no meas_done.
- pulser_ic_error: in any non-IDLE state it forces IDLE and pulses aborted once. tof, tof_valid and accumulators are unchanged. While it is high, trigger edges are ignored.
- Priority, same cycle: pulser_ic_error > trigger edge > echo/timeout.
  - Echo and timeout in the same MEASURE cycle: the echo is captured.
  - Set and reset_all_errors on the same timeout_err bit: set wins.
- Counter never wraps; the effective timeout is at most 2^CNT_W-1.

## Timing
- Async input high first sampled at edge E0 → edge event registered at E2 → the FSM acts at E3 (3-cycle latency).
- Echo timestamp = number of clk edges from the FSM leaving IDLE to the echo event, with identical sync latency on trigger and echo paths.
- meas_done is asserted the cycle after the final capture or timeout. avg_valid is coincident with the meas_done of the completing shot.
- Back-to-back triggers are accepted from IDLE on the cycle after DONE.

## Structure
- Package restoration_pkg holds:
  - FSM state encoding (2 bits)
  - default widths
  - helper function for effective timeout (0 → max)
- Sub-module pulse_edge_sync (2-flop sync + registered rising-edge pulse), instantiated NUM_CH+1 times.
- Per-channel capture and accumulator logic in a generate loop.

## Test plan
- NUM_CH=4, blank=10, timeout=1000; echoes at +50/+60/+70/+80 cycles after trigger → tof = timestamps relative to FSM start, tof_valid=4'hF, meas_done once, timeout_err=0.
- Channel 2 never echoes, timeout=200 → DONE at counter 200, tof[2]=16'hFFFF, tof_valid=4'hB, timeout_err[2]=1. reset_all_errors clears it; a coincident new timeout keeps it set.
- Echo on channel 0 at counter 5 with blank=10, repeat at 30 → tof[0]=30.
- pulser_ic_error at counter 40 mid-MEASURE → aborted pulse, IDLE, no meas_done, previous tof unchanged. A trigger in the same cycle as the error is ignored.
- AVG_LOG2=2, four good shots with ch0 = 100, 101, 102, 104 → tof_avg[0]=101, avg_valid on the 4th meas_done only. An intervening timeout shot does not count.
- Retrigger at counter 30 in MEASURE → counter restarts; only the second shot produces meas_done. reset_n low mid-shot → all outputs 0 next cycle.
